combo_entry_ctrl: RTL

- Sequencing controller for the combination-lock core.
- Turns the raw 4-bit code nibble plus an enter strobe into captured digit sequences, compares each full sequence against a stored combination, and counts failed attempts.
- Enforces a timed lockout after too many failures and lets the stored combination be reprogrammed while the lock is open.
- Sits between the pad-level inputs and the lock status outputs.

---
 rtl/combo_entry_ctrl_if.sv | 41 ++++
 rtl/combo_entry_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/combo_entry_ctrl_if.sv
// Pad-side bundle for the combination-lock sequencer: raw pad inputs in,
// lock status out. The master side drives the pads; the slave side is the
// controller.
interface combo_entry_ctrl_if;

  logic [3:0] code;
  logic       enter;
  logic       relock;
  logic       prog;

  logic       unlocked;
  logic       error;
  logic       lockout;
  logic       prog_mode;
  logic [3:0] digit_cnt;

  modport master (
    output code,
    output enter,
    output relock,
    output prog,
    input  unlocked,
    input  error,
    input  lockout,
    input  prog_mode,
    input  digit_cnt
  );

  modport slave (
    input  code,
    input  enter,
    input  relock,
    input  prog,
    output unlocked,
    output error,
    output lockout,
    output prog_mode,
    output digit_cnt
  );

endinterface

// File: rtl/combo_entry_ctrl.sv
// Combination-lock sequencer: captures digit nibbles on enter edges, checks
// the full sequence against the stored combination, counts failures, enforces
// a timed lockout and allows reprogramming while open.
module combo_entry_ctrl #(
  parameter int unsigned         DIGITS         = 4,
  parameter int unsigned         MAX_FAILS      = 3,
  parameter int unsigned         LOCKOUT_CYCLES = 16,
  parameter logic [4*DIGITS-1:0] DEFAULT_COMBO  = 16'h1234
) (
  input logic               CLK,
  input logic               RST,
  combo_entry_ctrl_if.slave bus
);

  localparam int unsigned W = 4 * DIGITS;

  // digit_cnt value seen just before the sequence-completing capture
  localparam logic [3:0]  LastCnt   = 4'(DIGITS - 1);
  localparam logic [3:0]  MaxFails  = 4'(MAX_FAILS);
  localparam logic [15:0] LockLoad  = 16'(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheck,
    StOpen,
    StProg,
    StLockout
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   combo_q, combo_d;
  // Holds the entered digits in ENTRY and the new combination in PROG
  logic [W-1:0]   shift_q, shift_d;
  logic [3:0]     fail_q, fail_d;
  logic [15:0]    timer_q, timer_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           error_q, error_d;
  logic           enter_q;
  logic           prog_q;

  logic           cap;
  logic           prog_edge;
  logic [W-1:0]   shift_in;
  logic [3:0]     fail_inc;

  assign cap       = bus.enter & ~enter_q;
  assign prog_edge = bus.prog & ~prog_q;
  // First captured digit ends up in the most significant nibble
  assign shift_in  = {shift_q[W-5:0], bus.code};
  assign fail_inc  = fail_q + 4'd1;

  // Input edge-detect history; reset high so a held input never looks like an edge
  always_ff @(posedge CLK) begin
    if (!RST) begin
      enter_q <= 1'b1;
      prog_q  <= 1'b1;
    end else begin
      enter_q <= bus.enter;
      prog_q  <= bus.prog;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      combo_q <= DEFAULT_COMBO;
      shift_q <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      combo_q <= combo_d;
      shift_q <= shift_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Next-state logic; relock outranks prog edge, which outranks enter edge
  always_comb begin
    state_d = state_q;
    combo_d = combo_q;
    shift_d = shift_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    error_d = error_q;

    case (state_q)
      StIdle: begin
        if (!bus.relock && cap) begin
          shift_d = {{(W-4){1'b0}}, bus.code};
          cnt_d   = 4'd1;
          error_d = 1'b0;
          state_d = StEntry;
        end
      end

      StEntry: begin
        if (bus.relock) begin
          // Abandoned entry is not a failed attempt
          shift_d = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cap) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LastCnt) begin
            state_d = StCheck;
          end
        end
      end

      StCheck: begin
        // Single evaluation cycle; captures arriving now are dropped
        cnt_d   = '0;
        shift_d = '0;
        if (shift_q == combo_q) begin
          fail_d  = '0;
          state_d = StOpen;
        end else begin
          error_d = 1'b1;
          fail_d  = fail_inc;
          if (fail_inc == MaxFails) begin
            timer_d = LockLoad;
            state_d = StLockout;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StOpen: begin
        if (bus.relock) begin
          state_d = StIdle;
        end else if (prog_edge) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = StProg;
        end
      end

      StProg: begin
        if (bus.relock) begin
          // Abort leaves the stored combination untouched
          shift_d = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cap) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LastCnt) begin
            combo_d = shift_in;
            shift_d = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end

      StLockout: begin
        // Timer loaded with LOCKOUT_CYCLES, so exit on 1 gives exactly that many cycles
        if (timer_q == 16'd1) begin
          timer_d = '0;
          fail_d  = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs decoded from registered state only
  assign bus.unlocked  = (state_q == StOpen);
  assign bus.lockout   = (state_q == StLockout);
  assign bus.prog_mode = (state_q == StProg);
  assign bus.error     = error_q;
  assign bus.digit_cnt = cnt_q;

endmodule
